sprite_mover: RTL

Keyboard-driven sprite position controller for the VGA game layer, next generation of the single-sprite motion block. It converts the USB keycode into stepped sprite movement with a parametrised step size, bounds and sprite size. It adds a hold-to-repeat state machine with initial delay and repeat rate, and edge clamping or wrap-around. It exposes a look-ahead probe position so external map/colour logic can veto a step through `collision` before the step is applied.

---
 rtl/sprite_mover_if.sv | 22 ++
 rtl/sprite_mover.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sprite_mover_if.sv
// Keyboard/probe/position bundle between the game layer and sprite_mover.
interface sprite_mover_if;
  logic [7:0] keycode;
  logic       collision;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic [9:0] spriteX;
  logic [9:0] spriteY;
  logic [9:0] spriteS;
  logic [1:0] facing;
  logic       moving;

  modport master (
    output keycode, collision,
    input  probe_x, probe_y, spriteX, spriteY, spriteS, facing, moving
  );

  modport slave (
    input  keycode, collision,
    output probe_x, probe_y, spriteX, spriteY, spriteS, facing, moving
  );
endinterface

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite mover with hold-to-repeat, look-ahead probe and collision veto.
// Define SPRITE_MOVER_WRAP_EN to wrap at screen edges instead of clamping.
module sprite_mover #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int START_X      = 320,
  parameter int START_Y      = 240,
  parameter int SIZE         = 30,
  parameter int STEP         = 2,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic         frame_clk,
  input  logic         Reset,
  sprite_mover_if.slave bus
);

  localparam logic signed [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       facing_q, facing_d;
  logic             moving_q, moving_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;

  logic             key_vld;
  logic [1:0]       key_dir;
  logic             do_step;
  logic [9:0]       probe_x, probe_y;

  // Signed 11-bit candidate so a step below zero is caught by the lower bound.
  function automatic logic [9:0] step_axis(
    input logic [9:0]        pos,
    input logic              neg,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] cand;
    logic signed [10:0] res;
    cand = neg ? ($signed({1'b0, pos}) - STEP_S) : ($signed({1'b0, pos}) + STEP_S);
    res  = cand;
`ifdef SPRITE_MOVER_WRAP_EN
    if (cand < lo)      res = hi;
    else if (cand > hi) res = lo;
`else
    if (cand < lo)      res = lo;
    else if (cand > hi) res = hi;
`endif
    return res[9:0];
  endfunction

  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_UP;
    case (bus.keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h07:   key_dir = DIR_RIGHT;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      default: key_vld = 1'b0;
    endcase
  end

  // Probe always tracks the live keycode; a step commits exactly this value.
  always_comb begin
    probe_x = x_q;
    probe_y = y_q;
    if (key_vld) begin
      case (key_dir)
        DIR_UP:    probe_y = step_axis(y_q, 1'b1, Y_LO, Y_HI);
        DIR_RIGHT: probe_x = step_axis(x_q, 1'b0, X_LO, X_HI);
        DIR_DOWN:  probe_y = step_axis(y_q, 1'b0, Y_LO, Y_HI);
        default:   probe_x = step_axis(x_q, 1'b1, X_LO, X_HI);
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    facing_d = facing_q;
    do_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_vld) begin
          do_step  = 1'b1;
          dir_d    = key_dir;
          facing_d = key_dir;
          cnt_d    = '0;
          state_d  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!key_vld) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (key_dir != dir_q) begin
          do_step  = 1'b1;
          dir_d    = key_dir;
          facing_d = key_dir;
          cnt_d    = '0;
          state_d  = DELAY;
        end else if (cnt_q == ((state_q == DELAY) ? DELAY_LAST : RATE_LAST)) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Collision vetoes the move but not the schedule or the facing update.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    moving_d = 1'b0;
    if (do_step && !bus.collision) begin
      x_d      = probe_x;
      y_d      = probe_y;
      moving_d = 1'b1;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      facing_q <= DIR_UP;
      moving_q <= 1'b0;
      x_q      <= 10'(START_X);
      y_q      <= 10'(START_Y);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      facing_q <= facing_d;
      moving_q <= moving_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign bus.probe_x = probe_x;
  assign bus.probe_y = probe_y;
  assign bus.spriteX = x_q;
  assign bus.spriteY = y_q;
  assign bus.spriteS = 10'(SIZE);
  assign bus.facing  = facing_q;
  assign bus.moving  = moving_q;

endmodule
